// File: rtl/decode_ctrl_unit.sv
// -----------------------------------------------------------------------------
// decode_ctrl_unit
//
// Decode-stage control for the five-stage MIPS pipeline.  The D-stage
// instruction is decoded into next-PC, immediate-extension, destination and
// hazard controls.  Branches are resolved here by comparing the forwarded rs/rt
// operands.  Reserved encodings are reported as ExcCode 10 unless the fetch
// stage already raised an exception.  A D/E register captures the fields that
// the execute stage needs.
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous active-low clear of the D/E register
//   Flush      synchronous bubble insert into the D/E register
//   InstrD     instruction in D
//   ForwardD1  forwarded rs value
//   ForwardD2  forwarded rt value
//   ExcCodeD   exception code carried from F (0 = none)
//   NPCOp      0 = branch target, 1 = jump target
//   ExtOp      0 = zero-ext, 1 = sign-ext, 2 = imm16<<16, 3 = zero-ext
//   PCSrc      0 = PC+4, 1 = NPC target, 2 = ForwardD1, 3 = EPC
//   A3Sel      0 = $0, 1 = $31, 2 = rd, 3 = rt
//   GenD       write data (PC+8) is produced in D
//   MD         instruction uses the mult/div unit
//   D1Use      rs consumed in D
//   D2Use      rt consumed in D
//   BD         instruction has a delay slot
//   Equal      ForwardD1 == ForwardD2
//   LTZ        ForwardD1 < 0 (signed)
//   EQZ        ForwardD1 == 0
//   Imm32      extended immediate
//   ExcCodeDE  merged exception code
//   A3E        registered destination register number
//   Imm32E     registered extended immediate
//   GenE       registered GenD
//   MDE        registered MD
//   ExcCodeE   registered ExcCodeDE
// -----------------------------------------------------------------------------
module decode_ctrl_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Flush,
    input  logic [31:0] InstrD,
    input  logic [31:0] ForwardD1,
    input  logic [31:0] ForwardD2,
    input  logic [4:0]  ExcCodeD,
    output logic        NPCOp,
    output logic [1:0]  ExtOp,
    output logic [1:0]  PCSrc,
    output logic [1:0]  A3Sel,
    output logic        GenD,
    output logic        MD,
    output logic        D1Use,
    output logic        D2Use,
    output logic        BD,
    output logic        Equal,
    output logic        LTZ,
    output logic        EQZ,
    output logic [31:0] Imm32,
    output logic [4:0]  ExcCodeDE,
    output logic [4:0]  A3E,
    output logic [31:0] Imm32E,
    output logic        GenE,
    output logic        MDE,
    output logic [4:0]  ExcCodeE
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_COP0   = 6'b010000;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_ERET  = 6'b011000;

    // COP0 rs selectors
    localparam logic [4:0] CP0_MF = 5'b00000;
    localparam logic [4:0] CP0_MT = 5'b00100;
    localparam logic [4:0] CP0_CO = 5'b10000;

    // Control encodings
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_NPC   = 2'd1;
    localparam logic [1:0] PC_REG   = 2'd2;
    localparam logic [1:0] PC_EPC   = 2'd3;

    localparam logic [1:0] A3_ZERO = 2'd0;
    localparam logic [1:0] A3_RA   = 2'd1;
    localparam logic [1:0] A3_RD   = 2'd2;
    localparam logic [1:0] A3_RT   = 2'd3;

    localparam logic [4:0] EXC_RI = 5'd10;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign op    = InstrD[31:26];
    assign rs    = InstrD[25:21];
    assign rt    = InstrD[20:16];
    assign rd    = InstrD[15:11];
    assign funct = InstrD[5:0];
    assign imm16 = InstrD[15:0];

    // Operand comparisons used for branch resolution.
    assign Equal = (ForwardD1 == ForwardD2);
    assign LTZ   = ForwardD1[31];
    assign EQZ   = (ForwardD1 == 32'd0);

    logic       dec_npc_op;
    logic [1:0] dec_ext_op;
    logic [1:0] dec_pc_src;
    logic [1:0] dec_a3_sel;
    logic       dec_gen;
    logic       dec_md;
    logic       dec_d1_use;
    logic       dec_d2_use;
    logic       dec_bd;
    logic       ri;

    // Raw decode.  Branch and REGIMM arms set their shared controls before
    // looking at the condition, so an unrecognised REGIMM rt still leaves
    // stray controls here; they are cleared by the RI mask below.
    always_comb begin
        dec_npc_op = 1'b0;
        dec_ext_op = EXT_ZERO;
        dec_pc_src = PC_PLUS4;
        dec_a3_sel = A3_ZERO;
        dec_gen    = 1'b0;
        dec_md     = 1'b0;
        dec_d1_use = 1'b0;
        dec_d2_use = 1'b0;
        dec_bd     = 1'b0;
        ri         = 1'b0;

        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL,
                    FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        dec_a3_sel = A3_RD;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec_a3_sel = A3_RD;
                        dec_md     = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: begin
                        dec_md = 1'b1;
                    end
                    FN_JR: begin
                        dec_pc_src = PC_REG;
                        dec_d1_use = 1'b1;
                        dec_bd     = 1'b1;
                    end
                    FN_JALR: begin
                        dec_pc_src = PC_REG;
                        dec_d1_use = 1'b1;
                        dec_bd     = 1'b1;
                        dec_gen    = 1'b1;
                        dec_a3_sel = A3_RD;
                    end
                    default: ri = 1'b1;
                endcase
            end

            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                dec_ext_op = EXT_SIGN;
                dec_a3_sel = A3_RT;
            end

            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_ext_op = EXT_ZERO;
                dec_a3_sel = A3_RT;
            end

            OP_LUI: begin
                dec_ext_op = EXT_LUI;
                dec_a3_sel = A3_RT;
            end

            OP_SB, OP_SH, OP_SW: begin
                dec_ext_op = EXT_SIGN;
            end

            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                dec_ext_op = EXT_SIGN;
                dec_bd     = 1'b1;
                dec_d1_use = 1'b1;
                case (op)
                    OP_BEQ: begin
                        dec_d2_use = 1'b1;
                        dec_pc_src = Equal ? PC_NPC : PC_PLUS4;
                    end
                    OP_BNE: begin
                        dec_d2_use = 1'b1;
                        dec_pc_src = !Equal ? PC_NPC : PC_PLUS4;
                    end
                    OP_BLEZ: dec_pc_src = (LTZ || EQZ) ? PC_NPC : PC_PLUS4;
                    OP_BGTZ: dec_pc_src = (!LTZ && !EQZ) ? PC_NPC : PC_PLUS4;
                    default: begin
                        case (rt)
                            5'b00000: dec_pc_src = LTZ ? PC_NPC : PC_PLUS4;
                            5'b00001: dec_pc_src = !LTZ ? PC_NPC : PC_PLUS4;
                            default:  ri = 1'b1;
                        endcase
                    end
                endcase
            end

            OP_J: begin
                dec_npc_op = 1'b1;
                dec_pc_src = PC_NPC;
                dec_bd     = 1'b1;
            end

            OP_JAL: begin
                dec_npc_op = 1'b1;
                dec_pc_src = PC_NPC;
                dec_bd     = 1'b1;
                dec_gen    = 1'b1;
                dec_a3_sel = A3_RA;
            end

            OP_COP0: begin
                case (rs)
                    CP0_MF: dec_a3_sel = A3_RT;
                    CP0_MT: dec_a3_sel = A3_ZERO;
                    CP0_CO: begin
                        if (funct == FN_ERET) begin
                            dec_pc_src = PC_EPC;
                        end else begin
                            ri = 1'b1;
                        end
                    end
                    default: ri = 1'b1;
                endcase
            end

            default: ri = 1'b1;
        endcase
    end

    // A reserved instruction must not redirect the PC, write a register or
    // stall on hazards, so every control is forced to zero.
    always_comb begin
        NPCOp = 1'b0;
        ExtOp = EXT_ZERO;
        PCSrc = PC_PLUS4;
        A3Sel = A3_ZERO;
        GenD  = 1'b0;
        MD    = 1'b0;
        D1Use = 1'b0;
        D2Use = 1'b0;
        BD    = 1'b0;
        if (!ri) begin
            NPCOp = dec_npc_op;
            ExtOp = dec_ext_op;
            PCSrc = dec_pc_src;
            A3Sel = dec_a3_sel;
            GenD  = dec_gen;
            MD    = dec_md;
            D1Use = dec_d1_use;
            D2Use = dec_d2_use;
            BD    = dec_bd;
        end
    end

    // A fetch-stage exception is older than the decode one and wins.
    assign ExcCodeDE = (ri && (ExcCodeD == 5'd0)) ? EXC_RI : ExcCodeD;

    // Immediate extension; encoding 3 behaves like zero-extend.
    always_comb begin
        Imm32 = {16'd0, imm16};
        case (ExtOp)
            EXT_SIGN: Imm32 = {{16{imm16[15]}}, imm16};
            EXT_LUI:  Imm32 = {imm16, 16'd0};
            default:  Imm32 = {16'd0, imm16};
        endcase
    end

    // Destination register number travelling to E.
    logic [4:0] a3;

    always_comb begin
        a3 = 5'd0;
        case (A3Sel)
            A3_RA:   a3 = 5'd31;
            A3_RD:   a3 = rd;
            A3_RT:   a3 = rt;
            default: a3 = 5'd0;
        endcase
    end

    // D/E pipeline register.  Reset wins over Flush; a flush inserts a
    // bubble that writes $0 and carries no exception.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            A3E      <= 5'd0;
            Imm32E   <= 32'd0;
            GenE     <= 1'b0;
            MDE      <= 1'b0;
            ExcCodeE <= 5'd0;
        end else if (Flush) begin
            A3E      <= 5'd0;
            Imm32E   <= 32'd0;
            GenE     <= 1'b0;
            MDE      <= 1'b0;
            ExcCodeE <= 5'd0;
        end else begin
            A3E      <= a3;
            Imm32E   <= Imm32;
            GenE     <= GenD;
            MDE      <= MD;
            ExcCodeE <= ExcCodeDE;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_unit
//
// Table-driven bench for decode_ctrl_unit.  Each vector holds an instruction,
// operands and the expected decode; the expected D/E contents are queued when a
// vector is driven and popped after the capturing edge.  Hand-written
// sequences cover asynchronous reset and flush.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_unit;

    logic        Clk;
    logic        Reset;
    logic        Flush;
    logic [31:0] InstrD;
    logic [31:0] ForwardD1;
    logic [31:0] ForwardD2;
    logic [4:0]  ExcCodeD;
    logic        NPCOp;
    logic [1:0]  ExtOp;
    logic [1:0]  PCSrc;
    logic [1:0]  A3Sel;
    logic        GenD;
    logic        MD;
    logic        D1Use;
    logic        D2Use;
    logic        BD;
    logic        Equal;
    logic        LTZ;
    logic        EQZ;
    logic [31:0] Imm32;
    logic [4:0]  ExcCodeDE;
    logic [4:0]  A3E;
    logic [31:0] Imm32E;
    logic        GenE;
    logic        MDE;
    logic [4:0]  ExcCodeE;

    decode_ctrl_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .InstrD    (InstrD),
        .ForwardD1 (ForwardD1),
        .ForwardD2 (ForwardD2),
        .ExcCodeD  (ExcCodeD),
        .NPCOp     (NPCOp),
        .ExtOp     (ExtOp),
        .PCSrc     (PCSrc),
        .A3Sel     (A3Sel),
        .GenD      (GenD),
        .MD        (MD),
        .D1Use     (D1Use),
        .D2Use     (D2Use),
        .BD        (BD),
        .Equal     (Equal),
        .LTZ       (LTZ),
        .EQZ       (EQZ),
        .Imm32     (Imm32),
        .ExcCodeDE (ExcCodeDE),
        .A3E       (A3E),
        .Imm32E    (Imm32E),
        .GenE      (GenE),
        .MDE       (MDE),
        .ExcCodeE  (ExcCodeE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ctl packing: {NPCOp, ExtOp, PCSrc, A3Sel, GenD, MD, D1Use, D2Use, BD}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] fwd1;
        logic [31:0] fwd2;
        logic [4:0]  exc;
        logic [11:0] ctl;
        logic [2:0]  flags;
        logic [31:0] imm;
        logic [4:0]  excde;
        logic [4:0]  a3;
    } vec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] imm;
        logic        gen;
        logic        md;
        logic [4:0]  exc;
    } reg_t;

    vec_t vecs[$];
    reg_t expq[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [11:0] ctl(input logic npc, input logic [1:0] ext,
                                        input logic [1:0] pcs, input logic [1:0] a3s,
                                        input logic gen, input logic md, input logic d1,
                                        input logic d2, input logic bd);
        return {npc, ext, pcs, a3s, gen, md, d1, d2, bd};
    endfunction

    // R-type with rs=3, rt=7, rd=5
    function automatic logic [31:0] rins(input logic [5:0] fn);
        return {6'h00, 5'd3, 5'd7, 5'd5, 5'd0, fn};
    endfunction

    // I-type with rs=3, rt=7
    function automatic logic [31:0] iins(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd3, 5'd7, imm};
    endfunction

    function automatic logic [31:0] cop0(input logic [4:0] rs, input logic [5:0] fn);
        return {6'h10, rs, 5'd7, 5'd12, 5'd0, fn};
    endfunction

    task automatic addVec(input logic [31:0] instr, input logic [31:0] f1,
                          input logic [31:0] f2, input logic [4:0] exc,
                          input logic [11:0] c, input logic [2:0] fl,
                          input logic [31:0] imm, input logic [4:0] excde,
                          input logic [4:0] a3);
        vec_t v;
        v.instr = instr; v.fwd1 = f1; v.fwd2 = f2; v.exc = exc;
        v.ctl = c; v.flags = fl; v.imm = imm; v.excde = excde; v.a3 = a3;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] f1,
                                 input logic [31:0] f2, input logic [4:0] exc);
        InstrD    = instr;
        ForwardD1 = f1;
        ForwardD2 = f2;
        ExcCodeD  = exc;
    endtask

    task automatic pushExp(input logic [4:0] a3, input logic [31:0] imm,
                           input logic gen, input logic md, input logic [4:0] exc);
        reg_t r;
        r.a3 = a3; r.imm = imm; r.gen = gen; r.md = md; r.exc = exc;
        expq.push_back(r);
    endtask

    task automatic checkRegs(input string tag);
        reg_t r;
        if (expq.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            r = expq.pop_front();
            checkOutput({tag, " A3E"}, {27'd0, A3E}, {27'd0, r.a3});
            checkOutput({tag, " Imm32E"}, Imm32E, r.imm);
            checkOutput({tag, " GenE/MDE"}, {30'd0, GenE, MDE}, {30'd0, r.gen, r.md});
            checkOutput({tag, " ExcCodeE"}, {27'd0, ExcCodeE}, {27'd0, r.exc});
        end
    endtask

    task automatic checkRegsZero(input string tag);
        checkOutput({tag, " A3E"}, {27'd0, A3E}, 32'd0);
        checkOutput({tag, " Imm32E"}, Imm32E, 32'd0);
        checkOutput({tag, " GenE/MDE"}, {30'd0, GenE, MDE}, 32'd0);
        checkOutput({tag, " ExcCodeE"}, {27'd0, ExcCodeE}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [31:0] JTGT = {6'h02, 26'h0123456};
    localparam logic [31:0] JAL  = {6'h03, 26'h0123456};
    localparam logic [31:0] P    = 32'h12345678;
    localparam logic [31:0] PN   = 32'h12345679;
    localparam logic [31:0] NEG  = 32'h80000000;

    initial begin
        vec_t  v;
        string tag;

        // R-type
        addVec(rins(6'h21), 32'h10, 32'h20, 5'd0, ctl(0,0,0,2,0,0,0,0,0), 3'b000, 32'h00002821, 5'd0, 5'd5);
        addVec(rins(6'h22), 32'h10, 32'h20, 5'd0, ctl(0,0,0,2,0,0,0,0,0), 3'b000, 32'h00002822, 5'd0, 5'd5);
        addVec(rins(6'h00), 32'h10, 32'h20, 5'd0, ctl(0,0,0,2,0,0,0,0,0), 3'b000, 32'h00002800, 5'd0, 5'd5);
        addVec(rins(6'h2B), 32'h10, 32'h20, 5'd0, ctl(0,0,0,2,0,0,0,0,0), 3'b000, 32'h0000282B, 5'd0, 5'd5);
        addVec(rins(6'h18), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,1,0,0,0), 3'b000, 32'h00002818, 5'd0, 5'd0);
        addVec(rins(6'h1B), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,1,0,0,0), 3'b000, 32'h0000281B, 5'd0, 5'd0);
        addVec(rins(6'h10), 32'h10, 32'h20, 5'd0, ctl(0,0,0,2,0,1,0,0,0), 3'b000, 32'h00002810, 5'd0, 5'd5);
        addVec(rins(6'h13), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,1,0,0,0), 3'b000, 32'h00002813, 5'd0, 5'd0);
        addVec(rins(6'h08), 32'h10, 32'h20, 5'd0, ctl(0,0,2,0,0,0,1,0,1), 3'b000, 32'h00002808, 5'd0, 5'd0);
        addVec(rins(6'h09), 32'h10, 32'h20, 5'd0, ctl(0,0,2,2,1,0,1,0,1), 3'b000, 32'h00002809, 5'd0, 5'd5);
        addVec(rins(6'h01), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00002801, 5'd10, 5'd0);
        addVec(rins(6'h21), 32'h10, 32'h20, 5'd4, ctl(0,0,0,2,0,0,0,0,0), 3'b000, 32'h00002821, 5'd4, 5'd5);
        // I-type and extension
        addVec(iins(6'h09, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,1,0,3,0,0,0,0,0), 3'b000, 32'hFFFF8001, 5'd0, 5'd7);
        addVec(iins(6'h0D, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,0,0,3,0,0,0,0,0), 3'b000, 32'h00008001, 5'd0, 5'd7);
        addVec(iins(6'h0F, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,2,0,3,0,0,0,0,0), 3'b000, 32'h80010000, 5'd0, 5'd7);
        addVec(iins(6'h0A, 16'h7FFF), 32'h10, 32'h20, 5'd0, ctl(0,1,0,3,0,0,0,0,0), 3'b000, 32'h00007FFF, 5'd0, 5'd7);
        addVec(iins(6'h0C, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,0,0,3,0,0,0,0,0), 3'b000, 32'h00008001, 5'd0, 5'd7);
        addVec(iins(6'h0E, 16'hFFFF), 32'h10, 32'h20, 5'd0, ctl(0,0,0,3,0,0,0,0,0), 3'b000, 32'h0000FFFF, 5'd0, 5'd7);
        addVec(iins(6'h23, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,1,0,3,0,0,0,0,0), 3'b000, 32'hFFFF8001, 5'd0, 5'd7);
        addVec(iins(6'h24, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,1,0,3,0,0,0,0,0), 3'b000, 32'hFFFF8001, 5'd0, 5'd7);
        addVec(iins(6'h2B, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,1,0,0,0,0,0,0,0), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h29, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,1,0,0,0,0,0,0,0), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        // Branches
        addVec(iins(6'h04, 16'h8001), P,      P,     5'd0, ctl(0,1,1,0,0,0,1,1,1), 3'b100, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h04, 16'h8001), P,      PN,    5'd0, ctl(0,1,0,0,0,0,1,1,1), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h05, 16'h8001), P,      PN,    5'd0, ctl(0,1,1,0,0,0,1,1,1), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h05, 16'h8001), P,      P,     5'd0, ctl(0,1,0,0,0,0,1,1,1), 3'b100, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h06, 16'h8001), NEG,    32'd0, 5'd0, ctl(0,1,1,0,0,0,1,0,1), 3'b010, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h06, 16'h8001), 32'd5,  32'd0, 5'd0, ctl(0,1,0,0,0,0,1,0,1), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h07, 16'h8001), 32'd0,  32'd0, 5'd0, ctl(0,1,0,0,0,0,1,0,1), 3'b101, 32'hFFFF8001, 5'd0, 5'd0);
        addVec(iins(6'h07, 16'h8001), 32'd5,  32'd0, 5'd0, ctl(0,1,1,0,0,0,1,0,1), 3'b000, 32'hFFFF8001, 5'd0, 5'd0);
        addVec({6'h01, 5'd3, 5'd0, 16'h8001}, NEG, 32'd0, 5'd0, ctl(0,1,1,0,0,0,1,0,1), 3'b010, 32'hFFFF8001, 5'd0, 5'd0);
        addVec({6'h01, 5'd3, 5'd1, 16'h8001}, NEG, 32'd0, 5'd0, ctl(0,1,0,0,0,0,1,0,1), 3'b010, 32'hFFFF8001, 5'd0, 5'd0);
        addVec({6'h01, 5'd3, 5'd1, 16'h8001}, 32'd0, 32'd0, 5'd0, ctl(0,1,1,0,0,0,1,0,1), 3'b101, 32'hFFFF8001, 5'd0, 5'd0);
        addVec({6'h01, 5'd3, 5'd2, 16'h8001}, 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00008001, 5'd10, 5'd0);
        // Jumps
        addVec(JTGT, 32'h10, 32'h20, 5'd0, ctl(1,0,1,0,0,0,0,0,1), 3'b000, 32'h00003456, 5'd0, 5'd0);
        addVec(JAL,  32'h10, 32'h20, 5'd0, ctl(1,0,1,1,1,0,0,0,1), 3'b000, 32'h00003456, 5'd0, 5'd31);
        // COP0
        addVec(cop0(5'b00000, 6'h00), 32'h10, 32'h20, 5'd0, ctl(0,0,0,3,0,0,0,0,0), 3'b000, 32'h00006000, 5'd0, 5'd7);
        addVec(cop0(5'b00100, 6'h00), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00006000, 5'd0, 5'd0);
        addVec({6'h10, 5'b10000, 15'd0, 6'h18}, 32'h10, 32'h20, 5'd0, ctl(0,0,3,0,0,0,0,0,0), 3'b000, 32'h00000018, 5'd0, 5'd0);
        addVec({6'h10, 5'b10000, 15'd0, 6'h01}, 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00000001, 5'd10, 5'd0);
        addVec(cop0(5'b00001, 6'h00), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00006000, 5'd10, 5'd0);
        // Reserved opcode
        addVec(iins(6'h3F, 16'h8001), 32'h10, 32'h20, 5'd0, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00008001, 5'd10, 5'd0);
        addVec(iins(6'h3F, 16'h8001), 32'h10, 32'h20, 5'd4, ctl(0,0,0,0,0,0,0,0,0), 3'b000, 32'h00008001, 5'd4, 5'd0);

        // Reset held from time zero with a live instruction on the inputs.
        Reset = 1'b0;
        Flush = 1'b0;
        applyStimulus(JAL, 32'h10, 32'h20, 5'd4);
        #12;
        checkRegsZero("reset");
        @(negedge Clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            @(negedge Clk);
            applyStimulus(v.instr, v.fwd1, v.fwd2, v.exc);
            #1;
            checkOutput({tag, " ctl"},
                        {20'd0, NPCOp, ExtOp, PCSrc, A3Sel, GenD, MD, D1Use, D2Use, BD},
                        {20'd0, v.ctl});
            checkOutput({tag, " flags"}, {29'd0, Equal, LTZ, EQZ}, {29'd0, v.flags});
            checkOutput({tag, " Imm32"}, Imm32, v.imm);
            checkOutput({tag, " ExcCodeDE"}, {27'd0, ExcCodeDE}, {27'd0, v.excde});
            pushExp(v.a3, v.imm, v.ctl[4], v.ctl[3], v.excde);
            @(posedge Clk);
            #1;
            checkRegs(tag);
        end

        // Asynchronous reset in the middle of a cycle.
        @(negedge Clk);
        applyStimulus(JAL, 32'h10, 32'h20, 5'd0);
        pushExp(5'd31, 32'h00003456, 1'b1, 1'b0, 5'd0);
        @(posedge Clk);
        #1;
        checkRegs("pre-reset jal");
        #2;
        Reset = 1'b0;
        #1;
        checkRegsZero("async reset");
        @(posedge Clk);
        #1;
        checkRegsZero("reset held");
        @(negedge Clk);
        Reset = 1'b1;
        pushExp(5'd31, 32'h00003456, 1'b1, 1'b0, 5'd0);
        @(posedge Clk);
        #1;
        checkRegs("post-reset jal");

        // Flush loads a bubble, then normal capture resumes.
        @(negedge Clk);
        applyStimulus({6'h00, 5'd3, 5'd7, 5'd9, 5'd0, 6'h09}, 32'h10, 32'h20, 5'd4);
        Flush = 1'b1;
        pushExp(5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        @(posedge Clk);
        #1;
        checkRegs("flush");
        @(negedge Clk);
        Flush = 1'b0;
        pushExp(5'd9, 32'h00004809, 1'b1, 1'b0, 5'd4);
        @(posedge Clk);
        #1;
        checkRegs("after flush jalr");

        // Reset asserted together with Flush still clears.
        @(negedge Clk);
        applyStimulus(rins(6'h10), 32'h10, 32'h20, 5'd3);
        Flush = 1'b1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkRegsZero("reset+flush");
        @(negedge Clk);
        Reset = 1'b1;
        Flush = 1'b0;
        pushExp(5'd5, 32'h00002810, 1'b0, 1'b1, 5'd3);
        @(posedge Clk);
        #1;
        checkRegs("mfhi capture");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
